debounce_btn: RTL and testbench

- Conditions a raw mechanical push-button input into the clean, active-low level `b` consumed by the pulse-stretch FSM stage (`b` low = pressed).
- Sits directly upstream of that FSM, in the same `clk` domain.
- Provides:
  - a 2-flop synchroniser;
  - a counter-based stability filter;
  - single-cycle press/release strobes for other consumers.

---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 23 ++
 rtl/debounce_btn.sv | 65 ++++++
 tb/tb_debounce_btn.sv | 111 +++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared button-level constants and parameter helpers for the debounce and
// pulse-stretch stages.
package btn_pkg;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  localparam int STABLE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 3;

  // True when a CNT_W-bit counter can reach stable-1 without wrapping.
  function automatic bit cnt_fits(input int stable, input int w);
    return (64'(1) << w) > 64'(stable - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_btn.sv
// Push-button conditioner: synchroniser, stability filter and registered
// press/release strobes. Output b is active-low (0 = pressed).
module debounce_btn
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic b,
  output logic press,
  output logic rel      // release strobe; "release" is a reserved word
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || !cnt_fits(STABLE_CYCLES, CNT_W)) begin : g_param_chk
    $error("debounce_btn: STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic             s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             b_nxt, press_nxt, rel_nxt;

  sync_2ff #(.RST_VAL(BTN_RELEASED)) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (btn_raw),
    .q   (s2)
  );

  // Any cycle where s2 agrees with b restarts the run; a full run commits.
  always_comb begin
    cnt_nxt   = '0;
    b_nxt     = b;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    if (s2 != b) begin
      if (cnt == CNT_MAX) begin
        b_nxt     = s2;
        press_nxt = (s2 == BTN_PRESSED);
        rel_nxt   = (s2 == BTN_RELEASED);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      b     <= BTN_RELEASED;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      b     <= b_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_btn.sv
// Directed bench for debounce_btn: driver pushes hand-computed post-edge
// expectations into a scoreboard queue, a monitor pops and checks each cycle.
module tb_debounce_btn;

  logic clk = 1'b0;
  logic clr, btn_raw;
  logic b, press, rel;

  typedef struct {
    string tag;
    logic  b;
    logic  press;
    logic  rel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  debounce_btn #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .clr     (clr),
    .btn_raw (btn_raw),
    .b       (b),
    .press   (press),
    .rel     (rel)
  );

  always #5 clk = ~clk;

  // Apply inputs for one edge, then record the outputs expected after it.
  task automatic step(input string tag, input logic c, input logic raw,
                      input logic eb, input logic ep, input logic er);
    exp_t e;
    clr     = c;
    btn_raw = raw;
    @(posedge clk);
    #1;
    e.tag = tag; e.b = eb; e.press = ep; e.rel = er;
    sb.push_back(e);
  endtask

  // n edges with b committing on the 6th (index 5) edge of a held level.
  task automatic held(input string tag, input logic raw, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < 5)       step(tag, 1'b0, raw, ~raw, 1'b0, 1'b0);
      else if (i == 5) step(tag, 1'b0, raw, raw, ~raw, raw);
      else             step(tag, 1'b0, raw, raw, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (b !== e.b || press !== e.press || rel !== e.rel) begin
        errors++;
        $display("FAIL %s: got b=%b press=%b release=%b, want b=%b press=%b release=%b",
                 e.tag, b, press, rel, e.b, e.press, e.rel);
      end
    end
  end

  initial begin
    clr = 1'b1;
    btn_raw = 1'b1;

    // Reset hold with the pin low, then the first free edge.
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post_reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    held("clean_press", 1'b0, 8);
    held("clean_release", 1'b1, 8);

    // Three low cycles are one short of a commit.
    for (int i = 0; i < 3; i++) step("glitch", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("glitch", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Bounce 0,1,0,0,1,0 then held low: b falls on edge 10 of the sequence.
    begin
      logic [5:0] bnc;
      bnc = 6'b010010;
      for (int i = 0; i < 6; i++) step("bounce", 1'b0, bnc[5-i], 1'b1, 1'b0, 1'b0);
      for (int i = 6; i < 10; i++) step("bounce", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("bounce_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("bounce_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    held("release2", 1'b1, 8);

    // Reset during a partial count, then the full latency from reload.
    for (int i = 0; i < 3; i++) step("mid_count", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mid_count_clr", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    held("after_clr", 1'b0, 7);

    // Reset while pressed: b returns to 1 without a release strobe.
    step("clr_pressed", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    held("after_clr2", 1'b0, 7);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
